// File: rtl/mode_register_pkg.sv
// mode_register_pkg: operation encoding, priority decode and width limits for mode_register
package mode_register_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC,
        OP_SHL,
        OP_SHR
    } op_t;

    function automatic op_t decode_op(input logic load, input logic inc, input logic dec,
                                      input logic shl, input logic shr);
        return load ? OP_LOAD : inc ? OP_INC : dec ? OP_DEC : shl ? OP_SHL : shr ? OP_SHR : OP_HOLD;
    endfunction

endpackage

// File: rtl/mode_register_next.sv
// mode_register_next: next value and carry for one operation (saturation via MODE_REGISTER_SAT_EN)
module mode_register_next
    import mode_register_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur,
    input  op_t              op,
    input  logic [WIDTH-1:0] in,
    input  logic             sin,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_carry
);

`ifdef MODE_REGISTER_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic all_ones;
    logic all_zero;

    assign all_ones = &cur;
    assign all_zero = ~|cur;

    // arithmetic and shift selection; carry flags the wrap/borrow or the bit shifted out
    always_comb begin
        nxt = op == OP_LOAD ? in
            : op == OP_INC  ? ((SAT && all_ones) ? cur : cur + WIDTH'(1))
            : op == OP_DEC  ? ((SAT && all_zero) ? cur : cur - WIDTH'(1))
            : op == OP_SHL  ? {cur[WIDTH-2:0], sin}
            : op == OP_SHR  ? {sin, cur[WIDTH-1:1]}
            : cur;
        nxt_carry = op == OP_INC ? all_ones
                  : op == OP_DEC ? all_zero
                  : op == OP_SHL ? cur[WIDTH-1]
                  : op == OP_SHR ? cur[0]
                  : 1'b0;
    end

endmodule

// File: rtl/mode_register.sv
// mode_register: prioritised load/inc/dec/shift register with carry and zero flags (option MODE_REGISTER_SAT_EN)
module mode_register
    import mode_register_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter logic [63:0] RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST = RESET_VAL[WIDTH-1:0];

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mode_register: WIDTH out of range");
    end

    op_t              op;
    logic [WIDTH-1:0] nxt;
    logic             nxt_carry;

    assign op = decode_op(load, inc, dec, shl, shr);

    mode_register_next #(.WIDTH(WIDTH)) u_next (
        .cur       (out),
        .op        (op),
        .in        (in),
        .sin       (sin),
        .nxt       (nxt),
        .nxt_carry (nxt_carry)
    );

    // state flops: reset wins, hold keeps carry, zero is derived from the value being stored
    always_ff @(posedge clk) begin
        if (reset) begin
            out   <= RST;
            carry <= 1'b0;
            zero  <= RST == '0;
        end else begin
            out   <= nxt;
            carry <= op == OP_HOLD ? carry : nxt_carry;
            zero  <= nxt == '0;
        end
    end

endmodule
